// File: rtl/ps2_rx_deserializer.sv
// PS/2 receive deserializer: conditions the raw device clock/data pair,
// frames 11-bit PS/2 words and presents each good scan-code byte with a
// one-cycle strobe. Bad parity, bad stop bit and stalled frames are dropped
// and flagged with their own one-cycle strobes.
module ps2_rx_deserializer #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       global_clk,
    input  logic       global_rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_data_out,
    output logic       key_changed_out,
    output logic       parity_error,
    output logic       frame_error
);

    // FILTER_LEN >= 1 and TIMEOUT_CYCLES >= 2 are assumed.
    localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BITS_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]        r_clk_sync;
    logic [1:0]        r_data_sync;
    logic              r_filt_clk;
    logic              r_filt_prev;
    logic [FILT_W-1:0] r_filt_cnt;

    logic              w_clk_s;
    logic              w_data_s;
    logic              w_fall;

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];
    assign w_fall   = r_filt_prev & ~r_filt_clk;

    // Two-flop synchronizers; reset to the idle (high) bus level.
    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows the synchronized clock only
    // after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_filt_prev <= r_filt_clk;
            if (w_clk_s == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                r_filt_clk <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FILT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM and datapath
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [BITS_W-1:0] r_bit_cnt;
    logic [BITS_W-1:0] w_bit_cnt_nxt;
    logic              r_parity;
    logic              w_parity_nxt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [TO_W-1:0]   w_to_nxt;
    logic              w_timeout;
    logic              w_key_load;
    logic              w_perr_nxt;
    logic              w_ferr_nxt;

    // Compared one below the limit so the timeout strobe lands exactly
    // TIMEOUT_CYCLES cycles after the cycle holding the last fall.
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 2));

    // State register.
    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath-next and strobe decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_parity_nxt  = r_parity;
        w_to_nxt      = r_to_cnt;
        w_key_load    = 1'b0;
        w_perr_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;

        if (r_state == S_IDLE) begin
            w_to_nxt = '0;
            if (w_fall && !w_data_s) begin
                w_shift_nxt   = '0;
                w_bit_cnt_nxt = '0;
                w_state_nxt   = S_DATA;
            end
        end else if (w_fall) begin
            w_to_nxt = '0;
            case (r_state)
                S_DATA: begin
                    w_shift_nxt   = {w_data_s, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + BITS_W'(1);
                    if (r_bit_cnt == BITS_W'(7)) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_parity_nxt = w_data_s;
                    w_state_nxt  = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (!w_data_s) begin
                        w_ferr_nxt = 1'b1;
                    end else if (^{r_shift, r_parity}) begin
                        w_key_load = 1'b1;
                    end else begin
                        w_perr_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (w_timeout) begin
            w_to_nxt    = '0;
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            w_to_nxt = r_to_cnt + TO_W'(1);
        end
    end

    // Frame datapath registers.
    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_parity  <= w_parity_nxt;
            r_to_cnt  <= w_to_nxt;
        end
    end

    // Registered outputs: byte holds until the next good frame.
    always_ff @(posedge global_clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            key_data_out    <= 8'h00;
            key_changed_out <= 1'b0;
            parity_error    <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            key_changed_out <= w_key_load;
            parity_error    <= w_perr_nxt;
            frame_error     <= w_ferr_nxt;
            if (w_key_load) begin
                key_data_out <= r_shift;
            end
        end
    end

endmodule
